// File: rtl/alu_op_sequencer.sv
// Command FIFO plus IDLE/EXEC/HOLD sequencer that feeds an external combinational ALU.
// Optional macro ALU_SEQ_ERR_DROP_EN drops error results instead of presenting them.
module alu_op_sequencer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_s,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_s,
   input  logic [WIDTH-1:0] alu_o,
   input  logic             alu_err,
   input  logic             alu_l,
   input  logic             alu_und,
   input  logic             alu_of,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_o,
   output logic [3:0]       out_flags,
   output logic             busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int EW = 2 * WIDTH + 4;
   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [1:0]    state;
   logic [1:0]    next_state;
   logic          push;
   logic          pop;
   logic          handshake;
   logic [EW-1:0] head;

   assign in_ready  = (count < FULL);
   assign push      = in_valid && in_ready;
   assign handshake = out_valid && out_ready;
   assign head      = mem[rd_ptr];
   assign busy      = (count != '0) || (state != IDLE);

   // Pop decisions look only at the registered count, so a same-cycle push is never bypassed.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               next_state = EXEC;
            end
         end
         EXEC: begin
`ifdef ALU_SEQ_ERR_DROP_EN
            if (alu_err) begin
               if (count != '0) begin
                  pop        = 1'b1;
                  next_state = EXEC;
               end else begin
                  next_state = IDLE;
               end
            end else begin
               next_state = HOLD;
            end
`else
            next_state = HOLD;
`endif
         end
         HOLD: begin
            if (handshake) begin
               if (count != '0) begin
                  pop        = 1'b1;
                  next_state = EXEC;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_a, in_b, in_s};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         state  <= IDLE;
         alu_a  <= '0;
         alu_b  <= '0;
         alu_s  <= '0;
      end else begin
         state <= next_state;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            alu_a  <= head[EW-1 -: WIDTH];
            alu_b  <= head[EW-1-WIDTH -: WIDTH];
            alu_s  <= head[3:0];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Result registers load only in EXEC and are otherwise frozen until the HOLD handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_o     <= '0;
         out_flags <= '0;
      end else if (state == EXEC) begin
`ifdef ALU_SEQ_ERR_DROP_EN
         if (!alu_err) begin
            out_valid <= 1'b1;
            out_o     <= alu_o;
            out_flags <= {alu_err, alu_l, alu_und, alu_of};
         end
`else
         out_valid <= 1'b1;
         out_o     <= alu_err ? '0 : alu_o;
         out_flags <= {alu_err, alu_l, alu_und, alu_of};
`endif
      end else if ((state == HOLD) && handshake) begin
         out_valid <= 1'b0;
      end
   end

endmodule
